// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Optional parity state is present only with UART_TX_SCHED_PARITY_EN.
package uart_pkg;

    // Baud divisors for a 100 MHz system clock.
    localparam int B115200 = 868;
    localparam int B9600   = 10417;

`ifdef UART_TX_SCHED_PARITY_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: counts down from M-1 while enabled.
// Ports: clk, rst_n (async low), ena (count enable), tick (bit end).
import uart_pkg::*;

module uart_baud_tick #(
    parameter int M = B115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic tick
);

    localparam int            W   = clog2(M);
    localparam logic [W-1:0]  TOP = W'(M - 1);

    logic [W-1:0] r_cnt;

    // Held at TOP while disabled so the first tick lands M cycles
    // after enable rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= TOP;
        end else if (!ena) begin
            r_cnt <= TOP;
        end else if (r_cnt == '0) begin
            r_cnt <= TOP;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = ena && (r_cnt == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among 4 requesters.
// Ports: clk, rst_n, req[4], data[32], ack[4], gnt_id[2], busy, tx.
// Macro UART_TX_SCHED_PARITY_EN adds an even parity bit before stop.
import uart_pkg::*;

module uart_tx_sched #(
    parameter int M    = B115200,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [1:0]        gnt_id,
    output logic              busy,
    output logic              tx
);

    state_t          r_state;
    logic            r_tx;
    logic            r_busy;
    logic [NREQ-1:0] r_ack;
    logic [1:0]      r_gnt;
    logic [1:0]      r_rr_ptr;
    logic [7:0]      r_shift;
    logic [2:0]      r_idx;
`ifdef UART_TX_SCHED_PARITY_EN
    logic            r_par;
`endif

    logic            w_ena;
    logic            w_tick;
    logic            w_any;
    logic [1:0]      w_sel;
    logic [7:0]      w_byte;

    assign w_ena = (r_state != IDLE);

    uart_baud_tick #(.M(M)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (w_ena),
        .tick  (w_tick)
    );

    // First requesting index at or after rr_ptr; scanning offsets
    // downwards lets the smallest offset win.
    always_comb begin
        w_any = |req;
        w_sel = r_rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[r_rr_ptr + 2'(k)]) w_sel = r_rr_ptr + 2'(k);
        end
    end

    assign w_byte = data[{w_sel, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_ack    <= '0;
            r_gnt    <= 2'd0;
            r_rr_ptr <= 2'd0;
            r_shift  <= 8'd0;
            r_idx    <= 3'd0;
`ifdef UART_TX_SCHED_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= START;
                        r_shift <= w_byte;
                        r_gnt   <= w_sel;
                        r_ack   <= NREQ'(1) << w_sel;
                        r_busy  <= 1'b1;
                        r_tx    <= 1'b0;
`ifdef UART_TX_SCHED_PARITY_EN
                        r_par   <= ^w_byte;
`endif
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_idx   <= 3'd0;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
                            r_state <= PAR;
                            r_tx    <= r_par;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
`ifdef UART_TX_SCHED_PARITY_EN
                PAR: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= r_gnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack    = r_ack;
    assign gnt_id = r_gnt;
    assign busy   = r_busy;
    assign tx     = r_tx;

endmodule
